// File: rtl/morse_letter_decoder.sv
// -----------------------------------------------------------------------------
// morse_letter_decoder
//
// Collects dit/dash events from the pulse interpreter into a symbol pattern and
// turns it into an ASCII character when a letter or word boundary arrives.
// A word boundary adds a single space character. Repeated spaces are
// suppressed, and no space is produced before the first letter after reset.
//
// Ports
//   clock_1khz   in   1  system clock (same 1 kHz clock as pulse_interpreter)
//   rst          in   1  synchronous active-high reset
//   pulse_event  in   3  0 none, 1 dit, 2 dash, 3 letter end, 4 word end,
//                        5..7 ignored
//   char_code    out  8  ASCII code, qualified by char_valid (held otherwise)
//   char_valid   out  1  one-cycle strobe
//   char_err     out  1  one-cycle strobe, set with char_valid when the
//                        unknown-character code is emitted
//   symbol_count out  3  number of symbols currently buffered
// -----------------------------------------------------------------------------
module morse_letter_decoder #(
    parameter int          MAX_SYMBOLS  = 5,
    parameter logic [7:0]  UNKNOWN_CHAR = 8'h3F,
    parameter logic [7:0]  SPACE_CHAR   = 8'h20
) (
    input  logic       clock_1khz,
    input  logic       rst,
    input  logic [2:0] pulse_event,
    output logic [7:0] char_code,
    output logic       char_valid,
    output logic       char_err,
    output logic [2:0] symbol_count
);

    localparam logic [2:0] EV_DIT    = 3'd1;
    localparam logic [2:0] EV_DASH   = 3'd2;
    localparam logic [2:0] EV_LETTER = 3'd3;
    localparam logic [2:0] EV_WORD   = 3'd4;

    typedef enum logic [1:0] {
        COLLECT     = 2'd0,
        EMIT_LETTER = 2'd1,
        EMIT_SPACE  = 2'd2
    } state_t;

    state_t                   state_reg, state_next;
    logic [MAX_SYMBOLS-1:0]   pattern_reg, pattern_next;
    logic [2:0]               count_reg, count_next;
    logic                     overflow_reg, overflow_next;
    logic                     pending_space_reg, pending_space_next;
    logic                     last_was_space_reg, last_was_space_next;
    logic [7:0]               char_code_reg, char_code_next;
    logic                     char_valid_reg, char_valid_next;
    logic                     char_err_reg, char_err_next;

    logic                     is_symbol;
    logic [8:0]               lookup_result;

    // Returns {hit, ascii}. The first symbol received sits at bit cnt-1 of
    // pat, the most recent one at bit 0; dash = 1, dit = 0.
    function automatic logic [8:0] lookup(input logic [2:0] cnt, input logic [4:0] pat);
        logic [8:0] r;
        r = {1'b0, UNKNOWN_CHAR};
        case ({cnt, pat})
            {3'd1, 5'b00000}: r = {1'b1, 8'h45}; // E .
            {3'd1, 5'b00001}: r = {1'b1, 8'h54}; // T -
            {3'd2, 5'b00000}: r = {1'b1, 8'h49}; // I ..
            {3'd2, 5'b00001}: r = {1'b1, 8'h41}; // A .-
            {3'd2, 5'b00010}: r = {1'b1, 8'h4E}; // N -.
            {3'd2, 5'b00011}: r = {1'b1, 8'h4D}; // M --
            {3'd3, 5'b00000}: r = {1'b1, 8'h53}; // S ...
            {3'd3, 5'b00001}: r = {1'b1, 8'h55}; // U ..-
            {3'd3, 5'b00010}: r = {1'b1, 8'h52}; // R .-.
            {3'd3, 5'b00011}: r = {1'b1, 8'h57}; // W .--
            {3'd3, 5'b00100}: r = {1'b1, 8'h44}; // D -..
            {3'd3, 5'b00101}: r = {1'b1, 8'h4B}; // K -.-
            {3'd3, 5'b00110}: r = {1'b1, 8'h47}; // G --.
            {3'd3, 5'b00111}: r = {1'b1, 8'h4F}; // O ---
            {3'd4, 5'b00000}: r = {1'b1, 8'h48}; // H ....
            {3'd4, 5'b00001}: r = {1'b1, 8'h56}; // V ...-
            {3'd4, 5'b00010}: r = {1'b1, 8'h46}; // F ..-.
            {3'd4, 5'b00100}: r = {1'b1, 8'h4C}; // L .-..
            {3'd4, 5'b00110}: r = {1'b1, 8'h50}; // P .--.
            {3'd4, 5'b00111}: r = {1'b1, 8'h4A}; // J .---
            {3'd4, 5'b01000}: r = {1'b1, 8'h42}; // B -...
            {3'd4, 5'b01001}: r = {1'b1, 8'h58}; // X -..-
            {3'd4, 5'b01010}: r = {1'b1, 8'h43}; // C -.-.
            {3'd4, 5'b01011}: r = {1'b1, 8'h59}; // Y -.--
            {3'd4, 5'b01100}: r = {1'b1, 8'h5A}; // Z --..
            {3'd4, 5'b01101}: r = {1'b1, 8'h51}; // Q --.-
            {3'd5, 5'b00000}: r = {1'b1, 8'h35}; // 5
            {3'd5, 5'b00001}: r = {1'b1, 8'h34}; // 4
            {3'd5, 5'b00011}: r = {1'b1, 8'h33}; // 3
            {3'd5, 5'b00111}: r = {1'b1, 8'h32}; // 2
            {3'd5, 5'b01111}: r = {1'b1, 8'h31}; // 1
            {3'd5, 5'b10000}: r = {1'b1, 8'h36}; // 6
            {3'd5, 5'b11000}: r = {1'b1, 8'h37}; // 7
            {3'd5, 5'b11100}: r = {1'b1, 8'h38}; // 8
            {3'd5, 5'b11110}: r = {1'b1, 8'h39}; // 9
            {3'd5, 5'b11111}: r = {1'b1, 8'h30}; // 0
            default:          r = {1'b0, UNKNOWN_CHAR};
        endcase
        return r;
    endfunction

    assign is_symbol     = (pulse_event == EV_DIT) || (pulse_event == EV_DASH);
    assign lookup_result = lookup(count_reg, 5'(pattern_reg));

    // The character is decoded at the moment the boundary is seen and the
    // result is registered, so the strobe appears in the cycle the FSM spends
    // in the matching EMIT state.
    always_comb begin
        state_next          = state_reg;
        pattern_next        = pattern_reg;
        count_next          = count_reg;
        overflow_next       = overflow_reg;
        pending_space_next  = pending_space_reg;
        last_was_space_next = last_was_space_reg;
        char_code_next      = char_code_reg;
        char_valid_next     = 1'b0;
        char_err_next       = 1'b0;

        // Symbols are accepted in every state; the buffer was already
        // cleared when the previous letter was latched.
        if (is_symbol) begin
            if (count_reg < 3'(MAX_SYMBOLS)) begin
                pattern_next = {pattern_reg[MAX_SYMBOLS-2:0], (pulse_event == EV_DASH)};
                count_next   = count_reg + 3'd1;
            end else begin
                overflow_next = 1'b1;
            end
        end

        case (state_reg)
            COLLECT: begin
                if ((pulse_event == EV_LETTER || pulse_event == EV_WORD) && count_reg != 3'd0) begin
                    char_valid_next     = 1'b1;
                    last_was_space_next = 1'b0;
                    if (overflow_reg || !lookup_result[8]) begin
                        char_code_next = UNKNOWN_CHAR;
                        char_err_next  = 1'b1;
                    end else begin
                        char_code_next = lookup_result[7:0];
                    end
                    pattern_next       = '0;
                    count_next         = 3'd0;
                    overflow_next      = 1'b0;
                    pending_space_next = (pulse_event == EV_WORD);
                    state_next         = EMIT_LETTER;
                end else if (pulse_event == EV_WORD && !last_was_space_reg) begin
                    char_valid_next     = 1'b1;
                    char_code_next      = SPACE_CHAR;
                    last_was_space_next = 1'b1;
                    state_next          = EMIT_SPACE;
                end
            end
            EMIT_LETTER: begin
                if (pending_space_reg) begin
                    char_valid_next     = 1'b1;
                    char_code_next      = SPACE_CHAR;
                    last_was_space_next = 1'b1;
                    state_next          = EMIT_SPACE;
                end else begin
                    state_next = COLLECT;
                end
                pending_space_next = 1'b0;
            end
            EMIT_SPACE: begin
                state_next = COLLECT;
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clock_1khz) begin
        if (rst) begin
            state_reg          <= COLLECT;
            pattern_reg        <= '0;
            count_reg          <= 3'd0;
            overflow_reg       <= 1'b0;
            pending_space_reg  <= 1'b0;
            last_was_space_reg <= 1'b1;
            char_code_reg      <= 8'h00;
            char_valid_reg     <= 1'b0;
            char_err_reg       <= 1'b0;
        end else begin
            state_reg          <= state_next;
            pattern_reg        <= pattern_next;
            count_reg          <= count_next;
            overflow_reg       <= overflow_next;
            pending_space_reg  <= pending_space_next;
            last_was_space_reg <= last_was_space_next;
            char_code_reg      <= char_code_next;
            char_valid_reg     <= char_valid_next;
            char_err_reg       <= char_err_next;
        end
    end

    assign char_code    = char_code_reg;
    assign char_valid   = char_valid_reg;
    assign char_err     = char_err_reg;
    assign symbol_count = count_reg;

endmodule

// File: tb/tb_morse_letter_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_letter_decoder
//
// Directed bench for morse_letter_decoder. Events are driven 1 time unit after
// a rising edge and held for exactly one cycle; outputs are examined 1 time
// unit after the following edge. A negedge monitor logs every strobe so that
// whole sequences (and the absence of strobes) can be checked afterwards.
// -----------------------------------------------------------------------------
module tb_morse_letter_decoder;

    localparam logic [2:0] DIT  = 3'd1;
    localparam logic [2:0] DASH = 3'd2;
    localparam logic [2:0] LE   = 3'd3;
    localparam logic [2:0] WE   = 3'd4;

    logic       clock_1khz;
    logic       rst;
    logic [2:0] pulse_event;
    logic [7:0] char_code;
    logic       char_valid;
    logic       char_err;
    logic [2:0] symbol_count;

    int checks = 0;
    int errors = 0;

    // {char_err, char_code} of every strobe seen since the last clear
    logic [8:0] log_q[$];

    morse_letter_decoder dut (
        .clock_1khz  (clock_1khz),
        .rst         (rst),
        .pulse_event (pulse_event),
        .char_code   (char_code),
        .char_valid  (char_valid),
        .char_err    (char_err),
        .symbol_count(symbol_count)
    );

    initial clock_1khz = 1'b0;
    always #5 clock_1khz = ~clock_1khz;

    always @(negedge clock_1khz) begin
        if (char_valid === 1'b1) log_q.push_back({char_err, char_code});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one event for one cycle; on return the outputs of the
    // following cycle are visible.
    task automatic send(input logic [2:0] ev);
        pulse_event = ev;
        @(posedge clock_1khz);
        #1;
        pulse_event = 3'd0;
        $display("event %0d -> valid=%0b code=%02h err=%0b count=%0d",
                 ev, char_valid, char_code, char_err, symbol_count);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock_1khz);
            #1;
        end
    endtask

    task automatic send_n(input logic [2:0] ev, input int n);
        for (int i = 0; i < n; i++) begin
            send(ev);
            idle(2);
        end
    endtask

    initial begin
        rst         = 1'b1;
        pulse_event = 3'd0;
        idle(3);
        rst = 1'b0;

        // Reset state
        check("rst_count", 16'(symbol_count), 16'd0);
        check("rst_valid", 16'(char_valid), 16'd0);
        check("rst_code",  16'(char_code), 16'h00);
        check("rst_err",   16'(char_err), 16'd0);

        // 'A': dit, dash, letter end with 10-cycle gaps
        idle(10);
        send(DIT);
        check("a_count1", 16'(symbol_count), 16'd1);
        idle(10);
        send(DASH);
        check("a_count2", 16'(symbol_count), 16'd2);
        idle(10);
        send(LE);
        check("a_valid", 16'(char_valid), 16'd1);
        check("a_code",  16'(char_code), 16'h41);
        check("a_err",   16'(char_err), 16'd0);
        check("a_count0", 16'(symbol_count), 16'd0);
        idle(1);
        check("a_strobe_one_cycle", 16'(char_valid), 16'd0);
        check("a_code_held", 16'(char_code), 16'h41);
        idle(3);
        log_q.delete();

        // "SOS" followed by a word end
        send_n(DIT, 3);
        send(LE);
        idle(3);
        send_n(DASH, 3);
        send(LE);
        idle(3);
        send_n(DIT, 3);
        send(WE);
        check("sos_s2_valid", 16'(char_valid), 16'd1);
        check("sos_s2_code",  16'(char_code), 16'h53);
        idle(1);
        check("sos_sp_valid", 16'(char_valid), 16'd1);
        check("sos_sp_code",  16'(char_code), 16'h20);
        check("sos_sp_err",   16'(char_err), 16'd0);
        idle(1);
        check("sos_after_valid", 16'(char_valid), 16'd0);
        idle(3);
        check("sos_strobes", 16'(log_q.size()), 16'd4);
        if (log_q.size() == 4) begin
            check("sos_q0", 16'(log_q[0]), 16'h053);
            check("sos_q1", 16'(log_q[1]), 16'h04F);
            check("sos_q2", 16'(log_q[2]), 16'h053);
            check("sos_q3", 16'(log_q[3]), 16'h020);
        end
        log_q.delete();

        // Overflow: six dits
        send_n(DIT, 5);
        check("ovf_count5", 16'(symbol_count), 16'd5);
        send(DIT);
        check("ovf_count_sat", 16'(symbol_count), 16'd5);
        idle(2);
        send(LE);
        check("ovf_valid", 16'(char_valid), 16'd1);
        check("ovf_code",  16'(char_code), 16'h3F);
        check("ovf_err",   16'(char_err), 16'd1);
        check("ovf_count0", 16'(symbol_count), 16'd0);
        idle(3);

        // Unassigned pattern ..-- gives '?'
        send_n(DIT, 2);
        send_n(DASH, 2);
        send(LE);
        check("unk_code", 16'(char_code), 16'h3F);
        check("unk_err",  16'(char_err), 16'd1);
        idle(3);

        // Five dashes decode to '0'; the overflow flag must not carry over
        send_n(DASH, 5);
        send(LE);
        check("zero_valid", 16'(char_valid), 16'd1);
        check("zero_code",  16'(char_code), 16'h30);
        check("zero_err",   16'(char_err), 16'd0);
        idle(1);
        check("zero_err_strobe", 16'(char_err), 16'd0);
        idle(3);

        // Word end straight after reset, then 'E' with two back-to-back word ends
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        log_q.delete();
        idle(2);
        send(WE);
        check("lead_space_none", 16'(char_valid), 16'd0);
        idle(3);
        check("lead_space_log", 16'(log_q.size()), 16'd0);
        send(DIT);
        idle(2);
        send(WE);
        check("e_valid", 16'(char_valid), 16'd1);
        check("e_code",  16'(char_code), 16'h45);
        send(WE);
        check("e_sp_valid", 16'(char_valid), 16'd1);
        check("e_sp_code",  16'(char_code), 16'h20);
        idle(1);
        check("e_sp_end", 16'(char_valid), 16'd0);
        send(WE);
        check("repeat_space_none", 16'(char_valid), 16'd0);
        idle(4);
        check("e_strobes", 16'(log_q.size()), 16'd2);
        if (log_q.size() == 2) begin
            check("e_q0", 16'(log_q[0]), 16'h045);
            check("e_q1", 16'(log_q[1]), 16'h020);
        end

        // Reset mid-letter discards the buffer
        log_q.delete();
        send(DIT);
        send(DASH);
        check("mid_count2", 16'(symbol_count), 16'd2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mid_rst_count", 16'(symbol_count), 16'd0);
        check("mid_rst_valid", 16'(char_valid), 16'd0);
        send(LE);
        check("mid_le_valid", 16'(char_valid), 16'd0);
        idle(4);
        check("mid_strobes", 16'(log_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
